// File: rtl/apb_spi_if_if.sv
// APB slave-side bus bundle for apb_spi_if. AddrW is the PADDR width; addresses
// at or above 0x10 are treated as unmapped when AddrW is wider than 4.
interface apb_spi_if_if #(
  parameter int unsigned AddrW = 4
) ();
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [AddrW-1:0] PADDR;
  logic [31:0]      PWDATA;
  logic [31:0]      PRDATA;
  logic             PREADY;
  logic             PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_spi_if.sv
// APB register front-end for a 16-bit SPI core: CTRL/STATUS/TXDATA/RXDATA,
// a launch/busy FSM and done-edge capture of the received frame.
// Optional interrupt output enabled by defining APB_SPI_IRQ_EN.
module apb_spi_if #(
  parameter int unsigned FRAME_W = 16  // only 16 is supported
) (
  input  logic               clk,
  input  logic               rst,
  apb_spi_if_if.slave        apb,
  output logic               send,
  output logic [FRAME_W-1:0] data_in,
  input  logic [FRAME_W-1:0] data_out,
  input  logic               done
`ifdef APB_SPI_IRQ_EN
  ,
  output logic               irq
`endif
);

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy} state_e;

  state_e             state_q;
  logic               send_q;
  logic [FRAME_W-1:0] tx_q;
  logic [FRAME_W-1:0] rx_q;
  logic               rx_valid_q;
  logic               overrun_q;
  logic               done_q;
  logic               irq_en;

  logic       acc, wr, rd, mapped, busy;
  logic [1:0] sel;
  logic       done_rise, capture, err;
  logic       ctrl_wr_ok, start_ok, tx_wr_ok, st_wr, rx_rd;
  logic       unused_bits;

  assign acc       = apb.PSEL & apb.PENABLE;
  assign wr        = acc & apb.PWRITE;
  assign rd        = acc & ~apb.PWRITE;
  assign mapped    = ~|(apb.PADDR >> 4);
  assign sel       = apb.PADDR[3:2];
  assign busy      = (state_q != StIdle);
  assign done_rise = done & ~done_q;
  assign capture   = (state_q == StBusy) & done_rise;

  assign ctrl_wr_ok = wr & mapped & (sel == 2'd0) & ~err;
  assign start_ok   = ctrl_wr_ok & apb.PWDATA[0];
  assign tx_wr_ok   = wr & mapped & (sel == 2'd2) & ~err;
  assign st_wr      = wr & mapped & (sel == 2'd1);
  assign rx_rd      = rd & mapped & (sel == 2'd3);

  assign unused_bits = ^{apb.PWDATA[31:FRAME_W], apb.PADDR[1:0]};

  assign send        = send_q;
  assign data_in     = tx_q;
  assign apb.PREADY  = 1'b1;

  // Error decode: unmapped, RXDATA write, or START/TXDATA write while busy.
  always_comb begin
    err = 1'b0;
    if (acc) begin
      if (!mapped) begin
        err = 1'b1;
      end else if (apb.PWRITE) begin
        case (sel)
          2'd0:    err = apb.PWDATA[0] & busy;
          2'd2:    err = busy;
          2'd3:    err = 1'b1;
          default: err = 1'b0;
        endcase
      end
    end
  end

  // Read mux; zero outside a mapped read access phase and during reset.
  always_comb begin
    apb.PRDATA = '0;
    if (rd && mapped && !rst) begin
      case (sel)
        2'd0:    apb.PRDATA = {30'd0, irq_en, 1'b0};
        2'd1:    apb.PRDATA = {29'd0, overrun_q, rx_valid_q, busy};
        2'd2:    apb.PRDATA = 32'(tx_q);
        default: apb.PRDATA = 32'(rx_q);
      endcase
    end
  end

  // PSLVERR is forced low while reset is held.
  always_comb begin
    apb.PSLVERR = err & ~rst;
  end

  // Transfer FSM with registered one-cycle send pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      send_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          send_q <= 1'b0;
          if (start_ok) begin
            state_q <= StLaunch;
            send_q  <= 1'b1;
          end
        end
        StLaunch: begin
          state_q <= StBusy;
          send_q  <= 1'b0;
        end
        StBusy: begin
          send_q <= 1'b0;
          if (capture) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          send_q  <= 1'b0;
        end
      endcase
    end
  end

  // Data and status registers; a capture wins over W1C and RXDATA-read clears.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q       <= '0;
      rx_q       <= '0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b1;  // a done already high at reset exit is not an edge
    end else begin
      done_q <= done;
      if (tx_wr_ok) tx_q <= apb.PWDATA[FRAME_W-1:0];
      if (capture) begin
        rx_q       <= data_out;
        rx_valid_q <= 1'b1;
      end else if ((st_wr && apb.PWDATA[1]) || rx_rd) begin
        rx_valid_q <= 1'b0;
      end
      if (capture && rx_valid_q) begin
        overrun_q <= 1'b1;
      end else if (st_wr && apb.PWDATA[2]) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef APB_SPI_IRQ_EN
  logic irq_en_q;
  logic irq_q;

  assign irq_en = irq_en_q;
  assign irq    = irq_q;

  // Interrupt enable and registered interrupt output.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (ctrl_wr_ok) irq_en_q <= apb.PWDATA[1];
      irq_q <= irq_en_q & (rx_valid_q | overrun_q);
    end
  end
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: doc/apb_spi_if.md
APB_SPI_IF -- requirements
Module: apb_spi_if

Interface
REQ-001 Parameter: FRAME_W, default 16, SPI frame width in bits; only 16 is supported.
REQ-002 clk  input  1  single system clock; all logic is on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 PSEL  input  1  APB slave select.
REQ-005 PENABLE  input  1  APB access phase.
REQ-006 PWRITE  input  1  1 = write, 0 = read.
REQ-007 PADDR  input  4  byte address; bits [1:0] are ignored.
REQ-008 PWDATA  input  32  APB write data.
REQ-009 PRDATA  output  32  APB read data.
REQ-010 PREADY  output  1  APB ready; tied to 1 (zero wait states).
REQ-011 PSLVERR  output  1  APB error, valid in the access phase only.
REQ-012 send  output  1  one-cycle start pulse to the SPI core.
REQ-013 data_in  output  16  TX frame to the SPI core.
REQ-014 data_out  input  16  RX frame from the SPI core.
REQ-015 done  input  1  SPI core end-of-transfer level.
REQ-016 irq  output  1  interrupt; present only with APB_SPI_IRQ_EN (REQ-040).

Function
REQ-017 Register map: 0x0 CTRL, 0x4 STATUS, 0x8 TXDATA, 0xC RXDATA.
REQ-018 CTRL: bit0 START is write-only and reads 0; bit1 IRQ_EN is read/write; all other bits read 0.
REQ-019 STATUS bits: bit0 BUSY (read-only), bit1 RX_VALID (write-1-to-clear), bit2 OVERRUN (write-1-to-clear).
REQ-020 TXDATA[15:0] is read/write and drives data_in continuously; bits [31:16] read 0.
REQ-021 RXDATA[15:0] is read-only; an APB read of RXDATA clears RX_VALID on that access edge.
REQ-022 A transfer occurs only when PSEL=1 and PENABLE=1; register updates take effect at the end of that access-phase cycle.
REQ-023 PRDATA is combinational from the registers during a read access phase; it is 0 at all other times.
REQ-024 FSM states are IDLE, LAUNCH and BUSY.
REQ-025 IDLE -> LAUNCH: on a write to CTRL with PWDATA[0]=1.
REQ-026 LAUNCH: send=1 for exactly this cycle; the next state is BUSY.
REQ-027 BUSY -> IDLE: on the rising edge of done (done=1 while done_q=0). On that same edge, RXDATA <= data_out and RX_VALID <= 1.
REQ-028 BUSY status bit = 1 in the LAUNCH and BUSY states.
REQ-029 Capture while RX_VALID is already 1: set OVERRUN and overwrite RXDATA.
REQ-030 Write START, or write TXDATA, while BUSY=1: ignore the write and assert PSLVERR=1 in the access phase.
REQ-031 Access to an unmapped address, or a write to RXDATA: PSLVERR=1, no state change, PRDATA=0.
REQ-032 Capture in the same cycle as a STATUS W1C of RX_VALID or OVERRUN: set takes priority.
REQ-033 Capture in the same cycle as an RXDATA read: the read returns the old data, and RX_VALID stays 1.
REQ-034 Write to CTRL with START=1 and IRQ_EN in the same access: both take effect.
REQ-035 A done level that is already high on the exit from reset does not trigger a capture; done_q resets to 1.

Reset
REQ-036 When rst=1 at a clock edge: FSM=IDLE, send=0, TXDATA=0, RXDATA=0, CTRL=0, STATUS=0, done_q=1.
REQ-037 During reset: PRDATA=0, PSLVERR=0, PREADY=1, irq=0.
REQ-038 Reset asserted mid-transfer aborts to IDLE; a done edge arriving afterwards is only captured if a new START has been issued.

Configuration
REQ-039 The macro APB_SPI_IRQ_EN controls the interrupt feature.
REQ-040 With APB_SPI_IRQ_EN defined: the irq port exists and is registered: irq = IRQ_EN & (RX_VALID | OVERRUN).
REQ-041 Without APB_SPI_IRQ_EN: no irq port; CTRL bit1 is read-only 0; writes to it are ignored without error.

Verification
REQ-042 Write TXDATA=0xA5C3, then CTRL=0x1 -> data_in=0xA5C3, send high for exactly 1 cycle, BUSY=1; done rises with data_out=0x3C5A -> RXDATA=0x3C5A, STATUS=0x2.
REQ-043 Second transfer without reading RXDATA -> STATUS=0x6; write STATUS=0x6 -> STATUS=0x0.
REQ-044 Write TXDATA=0x1234 while BUSY -> PSLVERR=1, TXDATA keeps its prior value; read 0x10 -> PSLVERR=1, PRDATA=0.
REQ-045 Done edge in the same cycle as a STATUS write of 0x2 -> RX_VALID=1 afterwards.
REQ-046 rst=1 for 1 cycle during BUSY -> all registers 0, send=0; done held high afterwards -> no capture, STATUS=0.
REQ-047 With APB_SPI_IRQ_EN defined: CTRL=0x2, complete a transfer -> irq=1 one cycle after capture; read RXDATA -> irq=0 on the next cycle.
